// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel window controller and its line buffers.
package sobel_pkg;

    localparam int PIX_W     = 8;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-in / edge-out stream handshakes; master is the source/sink side, slave is the controller.
interface sobel_window_ctrl_if;
    import sobel_pkg::*;

    logic             in_valid;
    logic [PIX_W-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [PIX_W-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/sobel_line_buf.sv
// One row of pixel storage with a combinational read and a same-address write (read-before-write).
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int AW    = cnt_w(IMG_W)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem_q [IMG_W];

    assign rd_data = mem_q[addr];

    // Contents are deliberately not reset; each frame writes a row before reading it back.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Streams one raster frame through two line buffers and a 3x3 window feeding an external Sobel kernel.
// Optional binary edge map selected with SOBEL_THRESH_EN (adds the thresh input).
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    sobel_window_ctrl_if.slave bus,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8,
    input  logic [PIX_W-1:0] k_data,
`ifdef SOBEL_THRESH_EN
    input  logic [PIX_W-1:0] thresh,
`endif
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_e           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [PIX_W-1:0] win_q [3][3];
    logic [PIX_W-1:0] win_d [3][3];
    logic             win_valid_q, win_valid_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_data_q, out_data_d;
`ifdef SOBEL_THRESH_EN
    logic [PIX_W-1:0] thresh_q, thresh_d;
`endif

    logic             adv;
    logic             accept;
    logic [PIX_W-1:0] lb0_rd;
    logic [PIX_W-1:0] lb1_rd;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state_q == RUN) && adv;
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != IDLE);

    assign p0 = win_q[0][0];
    assign p1 = win_q[0][1];
    assign p2 = win_q[0][2];
    assign p3 = win_q[1][0];
    assign p5 = win_q[1][2];
    assign p6 = win_q[2][0];
    assign p7 = win_q[2][1];
    assign p8 = win_q[2][2];

    // lb0 holds the row two above the incoming pixel, lb1 the row directly above.
    sobel_line_buf #(.IMG_W(IMG_W), .AW(CW)) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (lb1_rd),
        .rd_data (lb0_rd)
    );

    sobel_line_buf #(.IMG_W(IMG_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (col_q),
        .wr_data (bus.in_data),
        .rd_data (lb1_rd)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_d       = win_q;
        win_valid_d = win_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        frame_done  = 1'b0;
`ifdef SOBEL_THRESH_EN
        thresh_d    = thresh_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
`ifdef SOBEL_THRESH_EN
                    thresh_d = thresh;
`endif
                end
            end
            RUN: begin
                if (accept && row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!win_valid_q && !out_valid_q) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb0_rd;
            win_d[1][2] = lb1_rd;
            win_d[2][2] = bus.in_data;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // Both pipeline stages move together; a stalled output freezes the whole window path.
        if (adv) begin
            win_valid_d = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);
            out_valid_d = win_valid_q;
`ifdef SOBEL_THRESH_EN
            out_data_d  = (k_data >= thresh_q) ? 8'hFF : 8'h00;
`else
            out_data_d  = k_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= '0;
                end
            end
`ifdef SOBEL_THRESH_EN
            thresh_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            win_q       <= win_d;
`ifdef SOBEL_THRESH_EN
            thresh_q    <= thresh_d;
`endif
        end
    end

endmodule
